// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Round-robin arbiter/sequencer sharing one combinational ALU between two
// requesters. Each accepted operation is registered onto the ALU inputs, the
// ALU result/zero flag is captured one cycle later, and the response is held
// on a valid/ready channel until the consumer takes it.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   reqN_valid/a/b/op           requester N operation (N = 0, 1)
//   reqN_ready                  requester N accepted this cycle (combinational)
//   resp_valid/ready            response handshake
//   resp_id/result/zero/err     response payload (err = unsupported op code)
//   alu_a/alu_b/alu_op          registered operands driven to the ALU
//   alu_result/alu_zero         combinational ALU outputs
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_op,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_op,
    output logic             req1_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_err,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_grant_q;
    logic             cur_id_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [3:0]       alu_op_q;
    logic             resp_valid_q;
    logic             resp_id_q;
    logic [WIDTH-1:0] resp_result_q;
    logic             resp_zero_q;
    logic             resp_err_q;

    logic             any_valid;
    logic             grant_id;
    logic             accept;
    logic             op_supported;

    // Grant selection: a tie goes to the requester that did not win last time.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        grant_id  = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant_q;
        end else begin
            grant_id = req1_valid;
        end
        accept = (state_q == IDLE) && any_valid && !reset;
    end

    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept &&  grant_id;

    // Encodings the ALU implements; anything else is reported as an error.
    always_comb begin
        op_supported = 1'b0;
        case (alu_op_q)
            4'b0000, 4'b0001, 4'b0010,
            4'b0110, 4'b0111, 4'b1100: op_supported = 1'b1;
            default:                   op_supported = 1'b0;
        endcase
    end

    // Sequencer: IDLE accepts, EXEC captures the ALU output, RESP holds it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            cur_id_q      <= 1'b0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= 4'b0000;
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= '0;
            resp_zero_q   <= 1'b0;
            resp_err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        alu_a_q      <= grant_id ? req1_a  : req0_a;
                        alu_b_q      <= grant_id ? req1_b  : req0_b;
                        alu_op_q     <= grant_id ? req1_op : req0_op;
                        cur_id_q     <= grant_id;
                        last_grant_q <= grant_id;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    resp_result_q <= alu_result;
                    resp_zero_q   <= alu_zero;
                    resp_err_q    <= !op_supported;
                    resp_id_q     <= cur_id_q;
                    resp_valid_q  <= 1'b1;
                    state_q       <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign resp_zero   = resp_zero_q;
    assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Bench for alu_arbiter: provides a behavioural ALU, keeps a transaction-level
// reference model, compares every cycle, and runs directed plus random traffic.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]   req0_op, req1_op;
    logic         req0_ready, req1_ready;
    logic         resp_valid, resp_ready, resp_id, resp_zero, resp_err;
    logic [W-1:0] resp_result;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic [3:0]   alu_op;
    logic         alu_zero;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_zero(resp_zero), .resp_err(resp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [3:0] op);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0110: return a - b;
            4'b0111: return (a < b) ? W'(1) : W'(0);
            4'b1100: return ~(a | b);
            default: return '0;
        endcase
    endfunction

    function automatic logic supported(input logic [3:0] op);
        return op inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    endfunction

    function automatic logic pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return !last;
        return v1;
    endfunction

    // The shared ALU, as seen by the DUT.
    assign alu_result = alu_fn(alu_a, alu_b, alu_op);
    assign alu_zero   = (alu_result == '0);

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one operation in flight, response visible two cycles after accept.
    logic         m_started = 1'b0;
    logic         m_pending;
    int           m_age;
    logic         m_last;
    logic         m_id;
    logic [W-1:0] m_a, m_b;
    logic [3:0]   m_op;

    always @(posedge clk) begin
        if (reset) begin
            m_started <= 1'b1;
            m_pending <= 1'b0;
            m_age     <= 0;
            m_last    <= 1'b1;
            m_id      <= 1'b0;
            m_a       <= '0;
            m_b       <= '0;
            m_op      <= 4'b0000;
        end else if (!m_pending) begin
            if (req0_valid || req1_valid) begin
                m_id      <= pick(req0_valid, req1_valid, m_last);
                m_last    <= pick(req0_valid, req1_valid, m_last);
                m_a       <= pick(req0_valid, req1_valid, m_last) ? req1_a  : req0_a;
                m_b       <= pick(req0_valid, req1_valid, m_last) ? req1_b  : req0_b;
                m_op      <= pick(req0_valid, req1_valid, m_last) ? req1_op : req0_op;
                m_pending <= 1'b1;
                m_age     <= 1;
            end
        end else if (m_age < 2) begin
            m_age <= m_age + 1;
        end else if (resp_ready) begin
            m_pending <= 1'b0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_started) begin
            logic open, g, rv;
            logic [W-1:0] res;
            open = !reset && !m_pending && (req0_valid || req1_valid);
            g    = pick(req0_valid, req1_valid, m_last);
            rv   = m_pending && (m_age >= 2);
            res  = alu_fn(m_a, m_b, m_op);
            chk("req0_ready", W'(req0_ready), W'(open && !g));
            chk("req1_ready", W'(req1_ready), W'(open && g));
            chk("resp_valid", W'(resp_valid), W'(rv));
            chk("alu_a", alu_a, m_a);
            chk("alu_b", alu_b, m_b);
            chk("alu_op", W'(alu_op), W'(m_op));
            if (rv) begin
                chk("resp_id", W'(resp_id), W'(m_id));
                chk("resp_result", resp_result, res);
                chk("resp_zero", W'(resp_zero), W'(res == '0));
                chk("resp_err", W'(resp_err), W'(!supported(m_op)));
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req0_ready || req1_ready) return;
        end
        checks++; errors++;
        $display("FAIL wait_ready: no grant within 20 cycles");
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (resp_valid) return;
        end
        checks++; errors++;
        $display("FAIL wait_resp: no response within 20 cycles");
    endtask

    // Single request from one requester, with literal result and latency checks.
    task automatic run_op(input logic id, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] er, input logic ez,
                          input logic ee);
        int lat;
        @(posedge clk); #1;
        if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        wait_ready();
        chk("lit_grant_id", W'(req1_ready), W'(id));
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        wait_resp(lat);
        chk("lit_latency", W'(lat), W'(2));
        chk("lit_result", resp_result, er);
        chk("lit_zero", W'(resp_zero), W'(ez));
        chk("lit_err", W'(resp_err), W'(ee));
        chk("lit_id", W'(resp_id), W'(id));
    endtask

    initial begin
        int lat, cnt;
        logic [3:0] ops [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110,
                                4'b0111, 4'b1100, 4'b0011, 4'b1111};
        reset = 1; resp_ready = 1;
        req0_valid = 0; req1_valid = 0;
        req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        repeat (2) @(posedge clk);
        #1 req0_valid = 1; req1_valid = 1;
        @(negedge clk);
        chk("lit_reset_ready", W'({req0_ready, req1_ready}), W'(0));
        chk("lit_reset_valid", W'(resp_valid), W'(0));
        chk("lit_reset_alu_a", alu_a, W'(0));
        @(posedge clk); #1;
        reset = 0; req0_valid = 0; req1_valid = 0;

        // Single ADD
        run_op(1'b0, 4'b0010, 5, 7, 12, 1'b0, 1'b0);

        // Restore last_grant to its reset value, then a tie
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1 reset = 0;
        req0_valid = 1; req0_op = 4'b0110; req0_a = 9;    req0_b = 9;
        req1_valid = 1; req1_op = 4'b0001; req1_a = 'h0F; req1_b = 'hF0;
        wait_ready();
        chk("lit_tie_r0", W'(req0_ready), W'(1));
        chk("lit_tie_r1", W'(req1_ready), W'(0));
        @(posedge clk); #1 req0_valid = 0;
        wait_resp(lat);
        chk("lit_tie_res0", resp_result, W'(0));
        chk("lit_tie_zero0", W'(resp_zero), W'(1));
        chk("lit_tie_id0", W'(resp_id), W'(0));
        wait_ready();
        chk("lit_tie_r1b", W'(req1_ready), W'(1));
        @(posedge clk); #1 req1_valid = 0;
        wait_resp(lat);
        chk("lit_tie_res1", resp_result, W'('hFF));
        chk("lit_tie_id1", W'(resp_id), W'(1));

        // Round-robin fairness with both held valid
        @(posedge clk); #1;
        req0_valid = 1; req0_op = 4'b0010; req0_a = 1; req0_b = 2;
        req1_valid = 1; req1_op = 4'b0010; req1_a = 3; req1_b = 4;
        for (int k = 0; k < 6; k++) begin
            wait_ready();
            chk("lit_rr_order", W'(req1_ready), W'(k % 2));
            @(negedge clk);
            chk("lit_rr_pulse", W'({req0_ready, req1_ready}), W'(0));
            wait_resp(lat);
        end
        @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
        repeat (4) @(posedge clk);

        // Backpressure with req1 waiting
        #1 resp_ready = 0;
        req0_valid = 1; req0_op = 4'b0000; req0_a = 'hF0F0; req0_b = 'hFF00;
        req1_valid = 1; req1_op = 4'b0001; req1_a = 1; req1_b = 2;
        wait_ready();
        chk("lit_bp_grant", W'(req0_ready), W'(1));
        @(posedge clk); #1 req0_valid = 0;
        wait_resp(lat);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("lit_bp_valid", W'(resp_valid), W'(1));
            chk("lit_bp_result", resp_result, W'('hF000));
            chk("lit_bp_id", W'(resp_id), W'(0));
            chk("lit_bp_ready", W'({req0_ready, req1_ready}), W'(0));
        end
        @(posedge clk); #1 resp_ready = 1;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (resp_valid && resp_ready && resp_id == 1'b0) cnt++;
        end
        chk("lit_bp_count", W'(cnt), W'(1));
        @(posedge clk); #1 req1_valid = 0;
        repeat (4) @(posedge clk);

        // Unsupported op, then unsigned SLT
        run_op(1'b1, 4'b0011, 3, 4, 0, 1'b1, 1'b1);
        run_op(1'b1, 4'b0111, 2, 3, 1, 1'b0, 1'b0);

        // Reset while the operation is in EXEC
        @(posedge clk); #1;
        req0_valid = 1; req0_op = 4'b1100; req0_a = 0; req0_b = 0;
        wait_ready();
        @(posedge clk); #1 req0_valid = 0; reset = 1;
        @(posedge clk); #1 reset = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("lit_rst_valid", W'(resp_valid), W'(0));
            chk("lit_rst_alu_a", alu_a, W'(0));
            chk("lit_rst_alu_op", W'(alu_op), W'(0));
        end
        run_op(1'b0, 4'b0010, 1, 1, 2, 1'b0, 1'b0);

        // Random traffic against the model
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            reset      = ($urandom_range(0, 79) == 0);
            resp_ready = ($urandom_range(0, 3) != 0);
            req0_valid = ($urandom_range(0, 2) != 0);
            req1_valid = ($urandom_range(0, 2) != 0);
            req0_op = ops[$urandom_range(0, 7)];
            req1_op = ops[$urandom_range(0, 7)];
            req0_a = W'($urandom_range(0, 15)); req0_b = W'($urandom_range(0, 15));
            req1_a = $urandom;                 req1_b = W'($urandom_range(0, 3));
        end
        @(posedge clk); #1;
        reset = 0; req0_valid = 0; req1_valid = 0; resp_ready = 1;
        repeat (6) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single combinational `alu` between two requesters, such as an address-generation path and an execute path. It accepts one operation per grant and drives the ALU from registered operands. It captures the result and zero flag, then returns them on a shared response channel with a valid/ready handshake. It sits between the requesting control logic and one `alu` instance, whose ports it drives directly.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; must match the `alu` datapath.

Ports (one clock `clk`; reset `reset` is synchronous and active-high):
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `req0_valid`, `req1_valid`  in  1 each  requester i presents an operation
- `req0_a`, `req0_b`, `req1_a`, `req1_b`  in  WIDTH each  operands
- `req0_op`, `req1_op`  in  4 each  ALU operation code
- `req0_ready`, `req1_ready`  out  1 each  requester i's operation accepted this cycle
- `resp_valid`  out  1  response available
- `resp_ready`  in  1  consumer takes response
- `resp_id`  out  1  index of the requester that owns the response
- `resp_result`  out  WIDTH  captured ALU result
- `resp_zero`  out  1  captured ALU zero flag
- `resp_err`  out  1  op code was not a supported encoding
- `alu_a`, `alu_b`  out  WIDTH each  to `alu.data_a` / `alu.data_b`
- `alu_op`  out  4  to `alu.operation`
- `alu_result`  in  WIDTH  from `alu.aluresult`
- `alu_zero`  in  1  from `alu.zero`

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - If no request is valid, stay in IDLE.
  - Otherwise grant one requester:
    - Only one valid: grant it.
    - Both valid: grant the requester that is not `last_grant`.
  - Assert the granted requester's `reqX_ready` in the same cycle. Ready is combinational: `state==IDLE` AND granted.
  - On the clock edge, register a/b/op into `alu_a`/`alu_b`/`alu_op`, set `cur_id`, set `last_grant` := granted index, and go to EXEC.
- EXEC:
  - The ALU is driven by the registered operands.
  - On the clock edge, capture `alu_result` → `resp_result` and `alu_zero` → `resp_zero`.
  - Set `resp_err` = 1 if op ∉ {0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR}. In that case the captured result is the ALU's default, 0, and `resp_zero` = 1.
  - Go to RESP.
- RESP:
  - `resp_valid`=1, `resp_id`=`cur_id`.
  - Result, zero and err are held stable until `resp_valid && resp_ready`, then go to IDLE.
- `last_grant` reset value is 1, so requester 0 wins the first tie.
- SLT is unsigned: ALU semantics are passed through unchanged. No arithmetic is performed in this block.
- A requester whose valid is deasserted before it is granted loses nothing: the request is not latched.
- No `reqX_ready` is asserted outside IDLE. Requests that arrive in EXEC or RESP wait.

## Timing
- Accept at cycle N. `alu_*` update at the N+1 edge. Result captured at the N+2 edge. `resp_valid`=1 during cycle N+2.
- Earliest next accept is the cycle after the response handshake, so peak throughput is 1 op per 3 cycles.
- Reset values:
  - state=IDLE, `last_grant`=1, `cur_id`=0.
  - `alu_a`=`alu_b`=0, `alu_op`=0000.
  - `resp_valid`=0, `resp_result`=0, `resp_zero`=0, `resp_err`=0, `resp_id`=0.
  - `req0_ready`=`req1_ready`=0.
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded. No response is produced, and the FSM returns to IDLE on the next cycle.
- Reset has priority over every handshake in the same cycle. `reqX_ready` is 0 while `reset`=1.
- The `alu_*` outputs hold their last operands after completion. They change only on accept.
- Back-to-back handshake: a RESP handshake in cycle M allows an accept in cycle M+1. There is no combinational path from `resp_ready` to `reqX_ready`.

## Test plan
- Single request: req0 ADD a=5, b=7 accepted at N → `resp_valid` at N+2 with result=12, zero=0, id=0, err=0.
- Tie after reset: both valid (req0 SUB 9−9, req1 OR 0x0F|0xF0) → req0 granted first with result=0, zero=1. Then req1 granted with result=0xFF, id=1.
- Round-robin fairness: both held valid for 6 ops → grant order 0,1,0,1,0,1. Each `reqX_ready` is a single-cycle pulse.
- Backpressure: `resp_ready`=0 for 5 cycles in RESP → result, id and zero stay stable, no `reqX_ready` pulses, and exactly one response is delivered when ready rises.
- Unsupported op: req1 op=0011 with a=3, b=4 → result=0, zero=1, err=1. A following SLT with a=2, b=3 → result=1, err=0.
- Reset in EXEC: req0 NOR accepted, reset asserted at N+1 → no `resp_valid` ever asserted, all outputs at reset values, and the next request after reset follows normal timing.
